// File: rtl/regseq_pkg.sv
// Shared constants, command/state encodings and parity helper for the register-file command sequencer.
// REGSEQ_PARITY_EN widens each stored entry by one even-parity bit.
package regseq_pkg;

   localparam int DEPTH = 4;
   localparam int WIDTH = 3;
   localparam int PTR_W = 2;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

`ifdef REGSEQ_PARITY_EN
   localparam int STORE_W = WIDTH + 1;
`else
   localparam int STORE_W = WIDTH;
`endif

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ  = 2'b01,
      OP_CLEAR = 2'b10,
      OP_SCAN  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_SCAN  = 2'd2
   } state_t;

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic even_parity(input logic [WIDTH-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/regseq_regfile.sv
// DEPTH x STORE_W flop register file: one synchronous write port, one combinational read port.
// Entry width grows by a parity bit when REGSEQ_PARITY_EN is defined.
module regseq_regfile
   import regseq_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [PTR_W-1:0]   waddr,
   input  logic [STORE_W-1:0] wdata,
   input  logic [PTR_W-1:0]   raddr,
   output logic [STORE_W-1:0] rdata
);

   logic [STORE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/regfile_cmd_sequencer.sv
// Tiny Tapeout top: edge-triggered command sequencer driving a 4x3 register file from the I/O pins.
// Optional REGSEQ_PARITY_EN adds per-entry even parity checked on READ and SCAN.
module regfile_cmd_sequencer
   import regseq_pkg::*;
(
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   logic             clk;
   logic             reset;
   logic             cmd_valid;
   op_t              op;
   logic [WIDTH-1:0] arg;

   assign clk       = io_in[0];
   assign reset     = io_in[1];
   assign cmd_valid = io_in[2];
   assign op        = op_t'(io_in[4:3]);
   assign arg       = io_in[7:5];

   state_t           state_q, state_d;
   logic [PTR_W-1:0] idx_q, idx_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] fill_q, fill_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dvalid_q, dvalid_d;
   logic             err_q, err_d;
   logic             cmd_q;

   logic               cmd_edge, accept, dropped;
   logic               wr_en, rd_check, parity_err;
   logic [PTR_W-1:0]   wr_addr, rd_addr;
   logic [WIDTH-1:0]   wr_data, rd_data;
   logic [STORE_W-1:0] wr_word, rd_word;

   regseq_regfile u_rf (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_word),
      .raddr (rd_addr),
      .rdata (rd_word)
   );

`ifdef REGSEQ_PARITY_EN
   assign wr_word    = {even_parity(wr_data), wr_data};
   assign parity_err = rd_check & (^rd_word);
`else
   assign wr_word    = wr_data;
   assign parity_err = rd_check & 1'b0;
`endif

   assign rd_data = rd_word[WIDTH-1:0];

   // SCAN/READ results are registered: the read port is addressed with the entry to show next cycle.
   always_comb begin
      cmd_edge = cmd_valid & ~cmd_q;
      accept   = cmd_edge & (state_q == ST_IDLE);
      dropped  = cmd_edge & (state_q != ST_IDLE);
      state_d  = state_q;
      idx_d    = idx_q;
      wptr_d   = wptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      dout_d   = dout_q;
      dvalid_d = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = wptr_q;
      wr_data  = arg;
      rd_addr  = arg[PTR_W-1:0];
      rd_check = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op)
                  OP_WRITE: begin
                     wr_en  = 1'b1;
                     wptr_d = wptr_q + 1'b1;
                  end
                  OP_READ: begin
                     rd_check = 1'b1;
                     dout_d   = rd_data;
                     dvalid_d = 1'b1;
                     rd_ptr_d = arg[PTR_W-1:0];
                  end
                  OP_CLEAR: begin
                     state_d = ST_CLEAR;
                     idx_d   = '0;
                     fill_d  = arg;
                  end
                  OP_SCAN: begin
                     state_d  = ST_SCAN;
                     idx_d    = '0;
                     rd_addr  = '0;
                     rd_check = 1'b1;
                     dout_d   = rd_data;
                     dvalid_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            wr_data = fill_q;
            if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               wptr_d  = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_SCAN: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else begin
               idx_d    = idx_q + 1'b1;
               rd_addr  = idx_q + 1'b1;
               rd_check = 1'b1;
               dout_d   = rd_data;
               dvalid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      err_d = err_q | dropped | parity_err;
   end

   // cmd_q resets high so a cmd_valid held through reset release is not taken as a new edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         wptr_q   <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         err_q    <= 1'b0;
         cmd_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wptr_q   <= wptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         err_q    <= err_d;
         cmd_q    <= cmd_valid;
      end
   end

   logic             busy;
   logic [PTR_W-1:0] ptr;

   assign busy   = (state_q != ST_IDLE);
   assign ptr    = busy ? idx_q : (dvalid_q ? rd_ptr_q : wptr_q);
   assign io_out = {err_q, busy, ptr, dvalid_q, dout_q};

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Directed self-checking bench for regfile_cmd_sequencer; io_out = {err, busy, ptr[1:0], dvalid, dout[2:0]}.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_regfile_cmd_sequencer;
   import regseq_pkg::*;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic [1:0] op;
   logic [2:0] arg;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int checks   = 0;
   int failures = 0;

   assign io_in = {arg, op, cmd_valid, reset, clk};

   regfile_cmd_sequencer u_dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
      end
   endtask

   // One-cycle command pulse; returns in the cycle after the accept edge.
   task automatic applyStimulus(input op_t op_v, input logic [2:0] arg_v);
      @(negedge clk);
      cmd_valid = 1'b1;
      op        = op_v;
      arg       = arg_v;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic check_scan(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                             input logic [2:0] e2, input logic [2:0] e3,
                             input logic err_exp, input logic [1:0] wptr_exp);
      logic [2:0] exp_data [4];
      logic [1:0] p;
      exp_data = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         p = 2'(i);
         checkOutput(tag, io_out, {err_exp, 1'b1, p, 1'b1, exp_data[i]});
      end
      @(negedge clk);
      checkOutput({tag, "_end"}, io_out & 8'hF8, {err_exp, 1'b0, wptr_exp, 1'b0, 3'b000});
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      op        = 2'b00;
      arg       = 3'b000;
      repeat (2) @(negedge clk);
      checkOutput("reset_state", io_out, 8'h00);
      reset = 1'b0;

      // Fill all four entries; write pointer wraps back to 0.
      applyStimulus(OP_WRITE, 3'd5);
      checkOutput("write1_ptr", io_out, 8'h10);
      applyStimulus(OP_WRITE, 3'd3);
      applyStimulus(OP_WRITE, 3'd7);
      applyStimulus(OP_WRITE, 3'd1);
      checkOutput("write4_wrap", io_out, 8'h00);
      applyStimulus(OP_SCAN, 3'd0);
      check_scan("scan1", 3'd5, 3'd3, 3'd7, 3'd1, 1'b0, 2'd0);

      // Fifth write lands in entry 0.
      applyStimulus(OP_WRITE, 3'd6);
      checkOutput("write5_ptr", io_out & 8'hF8, 8'h10);
      applyStimulus(OP_READ, 3'd0);
      checkOutput("read0", io_out, 8'h0E);
      @(negedge clk);
      checkOutput("read0_after", io_out & 8'hF8, 8'h10);

      // Bulk clear with fill value 2.
      applyStimulus(OP_CLEAR, 3'd2);
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         checkOutput("clear_busy", io_out & 8'hF8, {1'b0, 1'b1, 2'(i), 1'b0, 3'b000});
      end
      @(negedge clk);
      checkOutput("clear_end", io_out & 8'hF8, 8'h00);
      applyStimulus(OP_SCAN, 3'd0);
      check_scan("scan_clear", 3'd2, 3'd2, 3'd2, 3'd2, 1'b0, 2'd0);

      // New edge during SCAN is dropped and sets the sticky error.
      applyStimulus(OP_SCAN, 3'd0);
      checkOutput("drop_c1", io_out, 8'h4A);
      @(negedge clk);
      checkOutput("drop_c2", io_out, 8'h5A);
      cmd_valid = 1'b1;
      op        = OP_WRITE;
      arg       = 3'd7;
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("drop_c3", io_out, 8'hEA);
      @(negedge clk);
      checkOutput("drop_c4", io_out, 8'hFA);
      @(negedge clk);
      checkOutput("drop_end", io_out & 8'hF8, 8'h80);
      applyStimulus(OP_SCAN, 3'd0);
      check_scan("scan_after_drop", 3'd2, 3'd2, 3'd2, 3'd2, 1'b1, 2'd0);

      // cmd_valid held high across reset release is not a command.
      reset     = 1'b1;
      cmd_valid = 1'b1;
      op        = OP_WRITE;
      arg       = 3'd5;
      repeat (2) @(negedge clk);
      checkOutput("reset2_state", io_out, 8'h00);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("held_through_reset", io_out, 8'h00);
      cmd_valid = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1;
      arg       = 3'd4;
      repeat (10) @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("held_one_write", io_out, 8'h10);
      applyStimulus(OP_READ, 3'd0);
      checkOutput("held_read0", io_out, 8'h0C);
      applyStimulus(OP_READ, 3'd1);
      checkOutput("held_read1", io_out, 8'h18);

      // Reset in the second CLEAR cycle aborts cleanly.
      applyStimulus(OP_CLEAR, 3'd7);
      checkOutput("abort_c1", io_out, 8'h40);
      @(negedge clk);
      checkOutput("abort_c2", io_out, 8'h50);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_reset", io_out, 8'h00);
      reset = 1'b0;
      applyStimulus(OP_SCAN, 3'd0);
      check_scan("scan_after_abort", 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 2'd0);

`ifdef REGSEQ_PARITY_EN
      // Corrupt a stored bit of entry 1; reading it must raise err.
      applyStimulus(OP_WRITE, 3'd3);
      applyStimulus(OP_WRITE, 3'd5);
      applyStimulus(OP_READ, 3'd0);
      checkOutput("parity_ok_read", io_out, 8'h0B);
      @(negedge clk);
      u_dut.u_rf.mem[1][0] = ~u_dut.u_rf.mem[1][0];
      applyStimulus(OP_READ, 3'd1);
      checkOutput("parity_err", io_out & 8'h80, 8'h80);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
